// File: rtl/switch_in_pio_if.sv
// Avalon-MM responder bus bundle for switch_in_pio.
// The initiator (processor side) drives address/strobes/write data;
// the responder returns read data with a one-cycle response strobe.
interface switch_in_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/switch_in_pio.sv
// switch_in_pio: board-switch input port for the dnn_accel_system.
// Each switch is synchronised (2 flops), debounced (DEBOUNCE_CYCLES stable
// cycles), edge-detected into sticky flags and combined with a mask into a
// level interrupt. Register map (word address): 0 DATA, 1 EDGE (W1C),
// 2 MASK, 3 RAW. Reads have a fixed latency of one cycle.
// Build option: define SWIN_BOTH_EDGES_EN to flag falling edges as well as
// rising edges; by default only rising edges set EDGE.
module switch_in_pio #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  switch_in_pio_if.slave   bus,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_EDGE = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_RAW  = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] mask;

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] mask_next;
  logic [31:0]      rd_value;
  logic [31:0]      rdata_q;
  logic             rdv_q;

  // Write data above WIDTH has no destination register.
  logic unused_wdata;
  assign unused_wdata = ^bus.avs_writedata;

  // Two-flop synchroniser for the asynchronous switch levels.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync   <= '0;
    end else begin
      sync_1 <= sw_in;
      sync   <= sync_1;
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES disagreeing cycles.
  // NOTE: the counter array is reset explicitly; it is control state, not storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge detection, register writes, and read-mux selection.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    wdata     = bus.avs_writedata[WIDTH-1:0];
    clr       = '0;
    mask_next = mask;
    rd_value  = '0;

`ifdef SWIN_BOTH_EDGES_EN
    det = deb ^ deb_d;
`else
    det = deb & ~deb_d;
`endif

    if (bus.avs_write) begin
      if (bus.avs_address == ADDR_EDGE) clr       = wdata;
      if (bus.avs_address == ADDR_MASK) mask_next = wdata;
    end

    // A new edge wins over a same-cycle clear of that bit.
    edge_next = (edge_flags & ~clr) | det;

    case (reg_addr_e'(bus.avs_address))
      ADDR_DATA: rd_value[WIDTH-1:0] = deb;
      ADDR_EDGE: rd_value[WIDTH-1:0] = edge_flags;
      ADDR_MASK: rd_value[WIDTH-1:0] = mask;
      ADDR_RAW:  rd_value[WIDTH-1:0] = sync;
      default:   rd_value            = '0;
    endcase
  end

  // Sticky edge flags, interrupt mask and registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_flags <= '0;
      mask       <= '0;
      irq        <= 1'b0;
    end else begin
      edge_flags <= edge_next;
      mask       <= mask_next;
      irq        <= |(edge_next & mask_next);
    end
  end

  // Read response: capture the pre-write register value, valid one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      rdv_q <= bus.avs_read;
      if (bus.avs_read) rdata_q <= rd_value;
    end
  end

  // A response due in a reset cycle is suppressed so a read issued just
  // before reset never completes.
  assign bus.avs_readdatavalid = rdv_q & ~reset;
  assign bus.avs_readdata      = reset ? 32'h0 : rdata_q;

endmodule
